// File: rtl/l2tlb.sv
// l2tlb: shared second-level TLB sitting behind the per-port L1 TLBs.
//
// Set-associative, ASID-tagged, 4 KiB leaves only. L1 misses probe it before
// the page-table walker; walker leaf results fill it. sfence.vma flushes are
// handled here: flush-all and by-VA flushes finish in one cycle, by-ASID-only
// flushes walk every set (Busy=1 for SETS cycles).
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   LookupValid/Ready/VPN/ASID        lookup request (one per cycle)
//   RespValid/Hit/PPN/Flags           lookup response, one cycle after accept
//   FillValid/Ready/VPN/ASID/PPN/Flags walker leaf write (Flags bit5 = G)
//   FlushValid/VAEn/ASIDEn/VPN/ASID   sfence.vma request
//   FlushDone                         one-cycle completion pulse
//   Busy                              by-ASID flush walk in progress
module l2tlb #(
  parameter int SETS      = 16,
  parameter int WAYS      = 4,
  parameter int VPN_BITS  = 27,
  parameter int PPN_BITS  = 44,
  parameter int ASID_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 LookupValid,
  output logic                 LookupReady,
  input  logic [VPN_BITS-1:0]  LookupVPN,
  input  logic [ASID_BITS-1:0] LookupASID,
  output logic                 RespValid,
  output logic                 RespHit,
  output logic [PPN_BITS-1:0]  RespPPN,
  output logic [7:0]           RespFlags,
  input  logic                 FillValid,
  output logic                 FillReady,
  input  logic [VPN_BITS-1:0]  FillVPN,
  input  logic [ASID_BITS-1:0] FillASID,
  input  logic [PPN_BITS-1:0]  FillPPN,
  input  logic [7:0]           FillFlags,
  input  logic                 FlushValid,
  input  logic                 FlushVAEn,
  input  logic                 FlushASIDEn,
  input  logic [VPN_BITS-1:0]  FlushVPN,
  input  logic [ASID_BITS-1:0] FlushASID,
  output logic                 FlushDone,
  output logic                 Busy
);

  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int G_BIT    = 5;

  typedef enum logic {IDLE, WALK} state_t;

  // Valid and pLRU state must clear on reset (and valid in one cycle on a
  // flush-all), so they are packed flop vectors; entry payload is plain storage.
  logic [SETS-1:0][WAYS-1:0] valid_reg;
  logic [SETS-1:0][WAYS-2:0] plru_reg;
  logic [VPN_BITS-1:0]       tag_mem   [SETS][WAYS];
  logic [ASID_BITS-1:0]      asid_mem  [SETS][WAYS];
  logic [PPN_BITS-1:0]       ppn_mem   [SETS][WAYS];
  logic [7:0]                flags_mem [SETS][WAYS];

  state_t                state_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [SET_BITS-1:0]   walk_ctr_reg;
  logic [ASID_BITS-1:0]  walk_asid_reg;
  logic                  resp_valid_reg;
  logic                  resp_hit_reg;
  logic [PPN_BITS-1:0]   resp_ppn_reg;
  logic [7:0]            resp_flags_reg;

  // Lowest-index set bit of a way vector.
  function automatic logic [WAY_BITS-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WAY_BITS-1:0] w;
    w = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) w = WAY_BITS'(i);
    end
    return w;
  endfunction

  // Tree pLRU, heap-numbered nodes (node n at bit n-1). A node bit of 0 means
  // the victim lies in the left subtree. Touching a way points every node on
  // its path away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_BITS-1:0] way);
    logic [WAYS-2:0]     b;
    logic [WAY_BITS-1:0] wsh;
    logic                dir;
    int                  node;
    b    = bits;
    wsh  = way;
    node = 1;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir = wsh[WAY_BITS-1];
      wsh = wsh << 1;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node - 1) b[n] = ~dir;
      end
      node = 2 * node + (dir ? 1 : 0);
    end
    return b;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_BITS-1:0] v;
    logic                dir;
    int                  node;
    v    = '0;
    node = 1;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node - 1) dir = bits[n];
      end
      v    = (v << 1) | WAY_BITS'(dir);
      node = 2 * node + (dir ? 1 : 0);
    end
    return v;
  endfunction

  logic [SET_BITS-1:0] lk_set, fill_set, fv_set;
  logic [WAYS-1:0]     lk_match, fill_match, fv_kill, wk_kill;
  logic [WAY_BITS-1:0] lk_way, fill_way;
  logic                flush_acc, fill_acc, lk_acc;

  assign lk_set   = LookupVPN[SET_BITS-1:0];
  assign fill_set = FillVPN[SET_BITS-1:0];
  assign fv_set   = FlushVPN[SET_BITS-1:0];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign lk_match[gi] = valid_reg[lk_set][gi] &&
                          (tag_mem[lk_set][gi] == LookupVPN) &&
                          (flags_mem[lk_set][gi][G_BIT] || (asid_mem[lk_set][gi] == LookupASID));
    // A fill that would also hit an existing entry replaces it, so one
    // translation never occupies two ways.
    assign fill_match[gi] = valid_reg[fill_set][gi] &&
                            (tag_mem[fill_set][gi] == FillVPN) &&
                            (flags_mem[fill_set][gi][G_BIT] || (asid_mem[fill_set][gi] == FillASID));
    assign fv_kill[gi] = valid_reg[fv_set][gi] &&
                         (tag_mem[fv_set][gi] == FlushVPN) &&
                         (!FlushASIDEn ||
                          ((asid_mem[fv_set][gi] == FlushASID) && !flags_mem[fv_set][gi][G_BIT]));
    assign wk_kill[gi] = valid_reg[walk_ctr_reg][gi] &&
                         (asid_mem[walk_ctr_reg][gi] == walk_asid_reg) &&
                         !flags_mem[walk_ctr_reg][gi][G_BIT];
  end

  assign lk_way = lowest_set(lk_match);

  always_comb begin
    fill_way = plru_victim(plru_reg[fill_set]);
    if (|fill_match) begin
      fill_way = lowest_set(fill_match);
    end else if (|(~valid_reg[fill_set])) begin
      fill_way = lowest_set(~valid_reg[fill_set]);
    end
  end

  // Priority: flush > fill > lookup; a walk blocks everything.
  assign flush_acc = FlushValid && !busy_reg;
  assign fill_acc  = FillValid && !FlushValid && !busy_reg;
  assign lk_acc    = LookupValid && !FillValid && !FlushValid && !busy_reg;

  assign LookupReady = reset_n && !FillValid && !FlushValid && !busy_reg;
  assign FillReady   = reset_n && !FlushValid && !busy_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg      <= '0;
      plru_reg       <= '0;
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      walk_ctr_reg   <= '0;
      walk_asid_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_ppn_reg   <= '0;
      resp_flags_reg <= '0;
    end else begin
      done_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_ppn_reg   <= '0;
      resp_flags_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (flush_acc) begin
            if (FlushVAEn) begin
              valid_reg[fv_set] <= valid_reg[fv_set] & ~fv_kill;
              done_reg          <= 1'b1;
            end else if (FlushASIDEn) begin
              state_reg     <= WALK;
              busy_reg      <= 1'b1;
              walk_ctr_reg  <= '0;
              walk_asid_reg <= FlushASID;
            end else begin
              valid_reg <= '0;
              done_reg  <= 1'b1;
            end
          end else if (fill_acc) begin
            valid_reg[fill_set][fill_way] <= 1'b1;
            plru_reg[fill_set]            <= plru_touch(plru_reg[fill_set], fill_way);
          end else if (lk_acc) begin
            resp_valid_reg <= 1'b1;
            if (|lk_match) begin
              resp_hit_reg     <= 1'b1;
              resp_ppn_reg     <= ppn_mem[lk_set][lk_way];
              resp_flags_reg   <= flags_mem[lk_set][lk_way];
              plru_reg[lk_set] <= plru_touch(plru_reg[lk_set], lk_way);
            end
          end
        end
        WALK: begin
          valid_reg[walk_ctr_reg] <= valid_reg[walk_ctr_reg] & ~wk_kill;
          if (walk_ctr_reg == SET_BITS'(SETS - 1)) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            walk_ctr_reg <= '0;
          end else begin
            walk_ctr_reg <= walk_ctr_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      tag_mem[fill_set][fill_way]   <= FillVPN;
      asid_mem[fill_set][fill_way]  <= FillASID;
      ppn_mem[fill_set][fill_way]   <= FillPPN;
      flags_mem[fill_set][fill_way] <= FillFlags;
    end
  end

  assign RespValid = resp_valid_reg;
  assign RespHit   = resp_hit_reg;
  assign RespPPN   = resp_ppn_reg;
  assign RespFlags = resp_flags_reg;
  assign FlushDone = done_reg;
  assign Busy      = busy_reg;

endmodule

// File: tb/tb_l2tlb.sv
// tb_l2tlb: directed, table-driven bench for l2tlb (default parameters:
// 16 sets, 4 ways). A vector table of fills, lookups and flushes with
// hand-computed results, followed by hand-written multi-cycle sequences.
module tb_l2tlb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        LookupValid, LookupReady;
  logic [26:0] LookupVPN;
  logic [15:0] LookupASID;
  logic        RespValid, RespHit;
  logic [43:0] RespPPN;
  logic [7:0]  RespFlags;
  logic        FillValid, FillReady;
  logic [26:0] FillVPN;
  logic [15:0] FillASID;
  logic [43:0] FillPPN;
  logic [7:0]  FillFlags;
  logic        FlushValid, FlushVAEn, FlushASIDEn;
  logic [26:0] FlushVPN;
  logic [15:0] FlushASID;
  logic        FlushDone, Busy;

  always #5 clk = ~clk;

  l2tlb dut (
    .clk(clk), .reset_n(reset_n),
    .LookupValid(LookupValid), .LookupReady(LookupReady),
    .LookupVPN(LookupVPN), .LookupASID(LookupASID),
    .RespValid(RespValid), .RespHit(RespHit), .RespPPN(RespPPN), .RespFlags(RespFlags),
    .FillValid(FillValid), .FillReady(FillReady), .FillVPN(FillVPN), .FillASID(FillASID),
    .FillPPN(FillPPN), .FillFlags(FillFlags),
    .FlushValid(FlushValid), .FlushVAEn(FlushVAEn), .FlushASIDEn(FlushASIDEn),
    .FlushVPN(FlushVPN), .FlushASID(FlushASID),
    .FlushDone(FlushDone), .Busy(Busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam int OP_FILL = 0;
  localparam int OP_LK   = 1;
  localparam int OP_FL   = 2;

  typedef struct {
    int          op;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [43:0] ppn;
    logic [7:0]  flags;
    logic        vaen;
    logic        asiden;
    logic        exp_hit;
    logic [43:0] exp_ppn;
    logic [7:0]  exp_flags;
    int          exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_fill(input logic [26:0] vpn, input logic [15:0] asid,
                                   input logic [43:0] ppn, input logic [7:0] flags);
    vecs.push_back('{OP_FILL, vpn, asid, ppn, flags, 1'b0, 1'b0, 1'b0, 44'h0, 8'h0, 0});
  endfunction

  function automatic void add_lk(input logic [26:0] vpn, input logic [15:0] asid,
                                 input logic hit, input logic [43:0] ppn, input logic [7:0] flags);
    vecs.push_back('{OP_LK, vpn, asid, 44'h0, 8'h0, 1'b0, 1'b0, hit, ppn, flags, 0});
  endfunction

  function automatic void add_fl(input logic vaen, input logic asiden, input logic [26:0] vpn,
                                 input logic [15:0] asid, input int busy);
    vecs.push_back('{OP_FL, vpn, asid, 44'h0, 8'h0, vaen, asiden, 1'b0, 44'h0, 8'h0, busy});
  endfunction

  task automatic do_fill(input logic [26:0] vpn, input logic [15:0] asid,
                         input logic [43:0] ppn, input logic [7:0] flags);
    FillValid = 1'b1; FillVPN = vpn; FillASID = asid; FillPPN = ppn; FillFlags = flags;
    #1;
    check("fill_ready", 64'(FillReady), 64'h1);
    @(posedge clk); #1;
    FillValid = 1'b0;
    $display("fill   vpn=%h asid=%h ppn=%h flags=%h", vpn, asid, ppn, flags);
  endtask

  task automatic do_lookup(input logic [26:0] vpn, input logic [15:0] asid, input logic hit,
                           input logic [43:0] ppn, input logic [7:0] flags);
    LookupValid = 1'b1; LookupVPN = vpn; LookupASID = asid;
    #1;
    check("lookup_ready", 64'(LookupReady), 64'h1);
    @(posedge clk); #1;
    LookupValid = 1'b0;
    check("resp_valid", 64'(RespValid), 64'h1);
    check("resp_hit", 64'(RespHit), 64'(hit));
    check("resp_ppn", 64'(RespPPN), 64'(ppn));
    check("resp_flags", 64'(RespFlags), 64'(flags));
    $display("lookup vpn=%h asid=%h hit=%0d ppn=%h flags=%h", vpn, asid, RespHit, RespPPN, RespFlags);
  endtask

  task automatic do_flush(input logic vaen, input logic asiden, input logic [26:0] vpn,
                          input logic [15:0] asid, input int exp_busy);
    int n;
    FlushValid = 1'b1; FlushVAEn = vaen; FlushASIDEn = asiden; FlushVPN = vpn; FlushASID = asid;
    @(posedge clk); #1;
    FlushValid = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("flush_busy_cycles", 64'(n), 64'(exp_busy));
    check("flush_done", 64'(FlushDone), 64'h1);
    $display("flush  vaen=%0d asiden=%0d vpn=%h asid=%h busy_cycles=%0d", vaen, asiden, vpn, asid, n);
  endtask

  initial begin
    int   done_seen;
    reset_n = 1'b0;
    LookupValid = 1'b0; LookupVPN = '0; LookupASID = '0;
    FillValid = 1'b0; FillVPN = '0; FillASID = '0; FillPPN = '0; FillFlags = '0;
    FlushValid = 1'b0; FlushVAEn = 1'b0; FlushASIDEn = 1'b0; FlushVPN = '0; FlushASID = '0;

    // Reset state: all outputs low while held, ready right after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_lookup_ready", 64'(LookupReady), 64'h0);
    check("rst_fill_ready", 64'(FillReady), 64'h0);
    check("rst_resp_valid", 64'(RespValid), 64'h0);
    check("rst_busy", 64'(Busy), 64'h0);
    check("rst_flush_done", 64'(FlushDone), 64'h0);
    reset_n = 1'b1;
    #1;
    check("post_rst_lookup_ready", 64'(LookupReady), 64'h1);
    check("post_rst_fill_ready", 64'(FillReady), 64'h1);
    $display("reset  released");

    // Basic hit/miss by ASID.
    add_fill(27'h123, 16'd5, 44'hABC, 8'h0F);
    add_lk  (27'h123, 16'd5, 1'b1, 44'hABC, 8'h0F);
    add_lk  (27'h123, 16'd6, 1'b0, 44'h0, 8'h00);
    // Global entry survives an ASID walk; non-global entry of that ASID does not.
    add_fill(27'h040, 16'd1, 44'h555, 8'h2F);
    add_lk  (27'h040, 16'd9, 1'b1, 44'h555, 8'h2F);
    add_fill(27'h077, 16'd1, 44'h777, 8'h0F);
    add_lk  (27'h077, 16'd1, 1'b1, 44'h777, 8'h0F);
    add_fl  (1'b0, 1'b1, 27'h0, 16'd1, 16);
    add_lk  (27'h040, 16'd9, 1'b1, 44'h555, 8'h2F);
    add_lk  (27'h077, 16'd1, 1'b0, 44'h0, 8'h00);
    add_lk  (27'h123, 16'd5, 1'b1, 44'hABC, 8'h0F);
    // Same VPN in two ASIDs; flush by VA+ASID removes only one.
    add_fill(27'h200, 16'd2, 44'h222, 8'h0F);
    add_fill(27'h200, 16'd3, 44'h333, 8'h0F);
    add_fl  (1'b1, 1'b1, 27'h200, 16'd2, 0);
    add_lk  (27'h200, 16'd2, 1'b0, 44'h0, 8'h00);
    add_lk  (27'h200, 16'd3, 1'b1, 44'h333, 8'h0F);
    // Refill of an existing translation overwrites it.
    add_fill(27'h200, 16'd3, 44'h334, 8'h07);
    add_lk  (27'h200, 16'd3, 1'b1, 44'h334, 8'h07);
    // Flush by VA only: other VPNs in the same set stay.
    add_fl  (1'b1, 1'b0, 27'h200, 16'd0, 0);
    add_lk  (27'h200, 16'd3, 1'b0, 44'h0, 8'h00);
    add_lk  (27'h040, 16'd9, 1'b1, 44'h555, 8'h2F);
    // Flush all, including global entries.
    add_fl  (1'b0, 1'b0, 27'h0, 16'd0, 0);
    add_lk  (27'h040, 16'd9, 1'b0, 44'h0, 8'h00);
    add_lk  (27'h123, 16'd5, 1'b0, 44'h0, 8'h00);
    // pLRU: ways 0..3 of set 0 filled in order, way1 touched, 5th fill evicts way2.
    add_fill(27'h300, 16'd4, 44'h1000, 8'h0F);
    add_fill(27'h310, 16'd4, 44'h1001, 8'h0F);
    add_fill(27'h320, 16'd4, 44'h1002, 8'h0F);
    add_fill(27'h330, 16'd4, 44'h1003, 8'h0F);
    add_lk  (27'h310, 16'd4, 1'b1, 44'h1001, 8'h0F);
    add_fill(27'h340, 16'd4, 44'h1004, 8'h0F);
    add_lk  (27'h320, 16'd4, 1'b0, 44'h0, 8'h00);
    add_lk  (27'h310, 16'd4, 1'b1, 44'h1001, 8'h0F);
    add_lk  (27'h300, 16'd4, 1'b1, 44'h1000, 8'h0F);
    add_lk  (27'h330, 16'd4, 1'b1, 44'h1003, 8'h0F);
    add_lk  (27'h340, 16'd4, 1'b1, 44'h1004, 8'h0F);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FILL: do_fill(vecs[i].vpn, vecs[i].asid, vecs[i].ppn, vecs[i].flags);
        OP_LK:   do_lookup(vecs[i].vpn, vecs[i].asid, vecs[i].exp_hit, vecs[i].exp_ppn, vecs[i].exp_flags);
        default: do_flush(vecs[i].vaen, vecs[i].asiden, vecs[i].vpn, vecs[i].asid, vecs[i].exp_busy);
      endcase
    end

    // Response coinciding with a flush-all reflects pre-flush contents.
    LookupValid = 1'b1; LookupVPN = 27'h310; LookupASID = 16'd4;
    @(posedge clk); #1;
    LookupValid = 1'b0;
    FlushValid = 1'b1; FlushVAEn = 1'b0; FlushASIDEn = 1'b0;
    #1;
    check("preflush_resp_valid", 64'(RespValid), 64'h1);
    check("preflush_resp_hit", 64'(RespHit), 64'h1);
    check("preflush_resp_ppn", 64'(RespPPN), 64'h1001);
    @(posedge clk); #1;
    FlushValid = 1'b0;
    check("preflush_done", 64'(FlushDone), 64'h1);
    $display("seq    lookup vs flush-all hit=%0d", RespHit);
    do_lookup(27'h310, 16'd4, 1'b0, 44'h0, 8'h00);

    // Fill and lookup in the same cycle: fill wins, lookup goes next cycle and hits.
    FillValid = 1'b1; FillVPN = 27'h500; FillASID = 16'd7; FillPPN = 44'h5AA; FillFlags = 8'h0F;
    LookupValid = 1'b1; LookupVPN = 27'h500; LookupASID = 16'd7;
    #1;
    check("collide_lookup_ready", 64'(LookupReady), 64'h0);
    check("collide_fill_ready", 64'(FillReady), 64'h1);
    @(posedge clk); #1;
    FillValid = 1'b0;
    #1;
    check("collide_lookup_ready2", 64'(LookupReady), 64'h1);
    check("collide_no_resp", 64'(RespValid), 64'h0);
    @(posedge clk); #1;
    LookupValid = 1'b0;
    check("collide_resp_valid", 64'(RespValid), 64'h1);
    check("collide_resp_hit", 64'(RespHit), 64'h1);
    check("collide_resp_ppn", 64'(RespPPN), 64'h5AA);
    $display("seq    fill+lookup collision hit=%0d ppn=%h", RespHit, RespPPN);

    // Reset in walk cycle 3 aborts the walk: no FlushDone, everything invalid.
    do_fill(27'h600, 16'd8, 44'h600, 8'h0F);
    do_fill(27'h610, 16'd8, 44'h610, 8'h2F);
    do_lookup(27'h610, 16'd8, 1'b1, 44'h610, 8'h2F);
    FlushValid = 1'b1; FlushVAEn = 1'b0; FlushASIDEn = 1'b1; FlushASID = 16'd8;
    @(posedge clk); #1;
    FlushValid = 1'b0;
    check("walk_busy", 64'(Busy), 64'h1);
    check("walk_lookup_ready", 64'(LookupReady), 64'h0);
    check("walk_fill_ready", 64'(FillReady), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(Busy), 64'h0);
    check("abort_done", 64'(FlushDone), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (FlushDone === 1'b1 || Busy === 1'b1) done_seen++;
    end
    check("abort_no_done_or_busy", 64'(done_seen), 64'h0);
    $display("seq    reset mid-walk");
    do_lookup(27'h610, 16'd8, 1'b0, 44'h0, 8'h00);
    do_lookup(27'h500, 16'd7, 1'b0, 44'h0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
